// File: rtl/syscall_unit_if.sv
// Syscall handler bus: decoder/regfile inputs and the halt/display/statistics outputs.
interface syscall_unit_if #(
  parameter int unsigned DISP_W = 32,
  parameter int unsigned CNT_W  = 32
);
  logic              in_syscall;
  logic [31:0]       in_A;
  logic [31:0]       in_B;
  logic              in_go;
  logic              out_halt;
  logic [DISP_W-1:0] out_disp;
  logic              out_disp_upd;
  logic [1:0]        out_state;
  logic [CNT_W-1:0]  out_cycles;
  logic [15:0]       out_nsys;

  modport master (
    output in_syscall, in_A, in_B, in_go,
    input  out_halt, out_disp, out_disp_upd, out_state, out_cycles, out_nsys
  );

  modport slave (
    input  in_syscall, in_A, in_B, in_go,
    output out_halt, out_disp, out_disp_upd, out_state, out_cycles, out_nsys
  );
endinterface

// File: rtl/syscall_unit.sv
// Syscall handler: display latch, pause-until-resume-key, permanent halt.
// Optional cycle/syscall counters are built only when SYSCALL_STATS_EN is defined.
module syscall_unit #(
  parameter int unsigned DISP_W = 32,
  parameter int unsigned CNT_W  = 32
) (
  input logic           in_clk,
  input logic           in_rst,
  syscall_unit_if.slave bus
);

  typedef enum logic [1:0] {
    StRun   = 2'b00,
    StPause = 2'b01,
    StHalt  = 2'b10
  } state_e;

  state_e            state_q, state_d;
  logic [DISP_W-1:0] disp_q, disp_d;
  logic              upd_q, upd_d;
  logic              go_q;
  logic              go_edge;
  logic              accept;

  assign go_edge = bus.in_go & ~go_q;
  assign accept  = (state_q == StRun) & bus.in_syscall;

  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      state_q <= StRun;
      disp_q  <= '0;
      upd_q   <= 1'b0;
      go_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      disp_q  <= disp_d;
      upd_q   <= upd_d;
      go_q    <= bus.in_go;
    end
  end

  always_comb begin
    state_d = state_q;
    disp_d  = disp_q;
    upd_d   = 1'b0;
    unique case (state_q)
      StRun: begin
        if (accept) begin
          case (bus.in_A)
            32'd34: begin
              disp_d = bus.in_B[DISP_W-1:0];
              upd_d  = 1'b1;
            end
            32'd50:  state_d = StPause;
            32'd10:  state_d = StHalt;
            default: state_d = StRun;
          endcase
        end
      end
      // Only a fresh press resumes; a key held on entry must be released first.
      StPause: if (go_edge) state_d = StRun;
      StHalt:  state_d = StHalt;
      default: state_d = StRun;
    endcase
  end

  assign bus.out_halt     = (state_q != StRun);
  assign bus.out_state    = state_q;
  assign bus.out_disp     = disp_q;
  assign bus.out_disp_upd = upd_q;

`ifdef SYSCALL_STATS_EN
  logic [CNT_W-1:0] cycles_q;
  logic [15:0]      nsys_q;

  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      cycles_q <= '0;
      nsys_q   <= '0;
    end else begin
      if (state_q == StRun) cycles_q <= cycles_q + 1'b1;
      if (accept)           nsys_q   <= nsys_q + 1'b1;
    end
  end

  assign bus.out_cycles = cycles_q;
  assign bus.out_nsys   = nsys_q;
`else
  assign bus.out_cycles = '0;
  assign bus.out_nsys   = '0;
`endif

endmodule

// File: tb/tb_syscall_unit.sv
// Randomized bench for syscall_unit with a behavioural reference model and directed anchors.
module tb_syscall_unit;
  localparam int unsigned DISP_W = 32;
  localparam int unsigned CNT_W  = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  syscall_unit_if #(.DISP_W(DISP_W), .CNT_W(CNT_W)) bus ();

  syscall_unit #(.DISP_W(DISP_W), .CNT_W(CNT_W)) dut (
    .in_clk (clk),
    .in_rst (rst),
    .bus    (bus.slave)
  );

  int n_pass  = 0;
  int n_total = 0;
  bit armed   = 1'b0;

  // Reference model: 0 = run, 1 = pause, 2 = halt.
  int                m_state = 0;
  logic [DISP_W-1:0] m_disp  = '0;
  logic              m_upd   = 1'b0;
  logic [CNT_W-1:0]  m_cycles = '0;
  logic [15:0]       m_nsys  = '0;
  logic              m_go_prev = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    else n_pass++;
  endtask

  always @(posedge clk) begin
    if (rst) begin
      m_state   <= 0;
      m_disp    <= '0;
      m_upd     <= 1'b0;
      m_cycles  <= '0;
      m_nsys    <= '0;
      m_go_prev <= 1'b0;
    end else begin
      m_go_prev <= bus.in_go;
      m_upd     <= 1'b0;
      if (m_state == 0) begin
        m_cycles <= m_cycles + 1;
        if (bus.in_syscall) begin
          m_nsys <= m_nsys + 1;
          if (bus.in_A == 32'd34) begin
            m_disp <= bus.in_B[DISP_W-1:0];
            m_upd  <= 1'b1;
          end else if (bus.in_A == 32'd50) m_state <= 1;
          else if (bus.in_A == 32'd10) m_state <= 2;
        end
      end else if (m_state == 1 && bus.in_go && !m_go_prev) begin
        m_state <= 0;
      end
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      check("halt", 64'(bus.out_halt), 64'(m_state != 0));
      check("state", 64'(bus.out_state), 64'(m_state));
      check("disp", 64'(bus.out_disp), 64'(m_disp));
      check("disp_upd", 64'(bus.out_disp_upd), 64'(m_upd));
`ifdef SYSCALL_STATS_EN
      check("cycles", 64'(bus.out_cycles), 64'(m_cycles));
      check("nsys", 64'(bus.out_nsys), 64'(m_nsys));
`else
      check("cycles_tied", 64'(bus.out_cycles), 64'd0);
      check("nsys_tied", 64'(bus.out_nsys), 64'd0);
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sys(input logic [31:0] a, input logic [31:0] b);
    bus.in_syscall = 1'b1;
    bus.in_A       = a;
    bus.in_B       = b;
    tick();
    bus.in_syscall = 1'b0;
  endtask

  initial begin
    logic [31:0] codes [5];
    bus.in_syscall = 1'b0;
    bus.in_A       = '0;
    bus.in_B       = '0;
    bus.in_go      = 1'b0;
    rst            = 1'b1;
    tick();
    armed = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_halt", 64'(bus.out_halt), 64'd0);
    check("rst_state", 64'(bus.out_state), 64'd0);
    check("rst_disp", 64'(bus.out_disp), 64'd0);

    sys(32'd34, 32'h0000_00AB);
    check("d34_disp", 64'(bus.out_disp), 64'h0000_00AB);
    check("d34_upd", 64'(bus.out_disp_upd), 64'd1);
    check("d34_halt", 64'(bus.out_halt), 64'd0);
    tick();
    check("d34_upd_drop", 64'(bus.out_disp_upd), 64'd0);

    sys(32'd7, 32'h1234_5678);
    check("nop_state", 64'(bus.out_state), 64'd0);
    check("nop_disp", 64'(bus.out_disp), 64'h0000_00AB);
`ifdef SYSCALL_STATS_EN
    check("nop_nsys", 64'(bus.out_nsys), 64'd2);
`endif

    sys(32'd10, 32'h0);
    check("halt_halt", 64'(bus.out_halt), 64'd1);
    check("halt_state", 64'(bus.out_state), 64'd2);
    bus.in_go = 1'b1;
    tick();
    bus.in_go = 1'b0;
    sys(32'd34, 32'h0000_0055);
    check("halt_sticky", 64'(bus.out_state), 64'd2);
    check("halt_disp", 64'(bus.out_disp), 64'h0000_00AB);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("halt_rst_halt", 64'(bus.out_halt), 64'd0);
    check("halt_rst_disp", 64'(bus.out_disp), 64'd0);

    bus.in_go = 1'b1;
    sys(32'd50, 32'h0);
    repeat (3) tick();
    check("pause_held_key", 64'(bus.out_state), 64'd1);
    bus.in_go = 1'b0;
    tick();
    check("pause_released", 64'(bus.out_halt), 64'd1);
    bus.in_go = 1'b1;
    tick();
    check("resume", 64'(bus.out_halt), 64'd0);
    bus.in_go = 1'b0;

    rst = 1'b1;
    sys(32'd10, 32'h0);
    rst = 1'b0;
    check("rst_pri_state", 64'(bus.out_state), 64'd0);
    check("rst_pri_halt", 64'(bus.out_halt), 64'd0);

    codes[0] = 32'd34;
    codes[1] = 32'd50;
    codes[2] = 32'd10;
    codes[3] = 32'd7;
    codes[4] = 32'd0;
    for (int i = 0; i < 3000; i++) begin
      rst            = ($urandom_range(99) < 2);
      bus.in_syscall = ($urandom_range(99) < 35);
      bus.in_A       = ($urandom_range(9) == 0) ? $urandom : codes[$urandom_range(3)];
      bus.in_B       = $urandom;
      if ($urandom_range(99) < 20) bus.in_go = ~bus.in_go;
      tick();
    end
    rst            = 1'b0;
    bus.in_syscall = 1'b0;
    tick();
    armed = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
